dmem_subword: RTL and testbench

DMEM_SUBWORD -- requirements
Module: dmem_subword

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_subword.sv | 154 +++++++++++++++
 tb/tb_dmem_subword.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the sub-word data memory: access sizes, error codes
// and the controller state values.
package dmem_pkg;

  typedef logic [1:0] size_t;
  typedef logic [1:0] err_t;

  localparam size_t SIZE_BYTE  = 2'b00;
  localparam size_t SIZE_HALF  = 2'b01;
  localparam size_t SIZE_WORD  = 2'b10;
  localparam size_t SIZE_DWORD = 2'b11;

  localparam err_t ERR_OK       = 2'b00;
  localparam err_t ERR_MISALIGN = 2'b01;
  localparam err_t ERR_RANGE    = 2'b10;
  localparam err_t ERR_SIZE     = 2'b11;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Number of bytes moved by an access of the given size code.
  function automatic logic [3:0] size_bytes(input size_t size);
    case (size)
      SIZE_BYTE: size_bytes = 4'd1;
      SIZE_HALF: size_bytes = 4'd2;
      SIZE_WORD: size_bytes = 4'd4;
      default:   size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: positions store data and its bit mask in the
// addressed lanes, and right-justifies/extends load data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB    = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rword_i,
  output logic [DATA_WIDTH-1:0] wmask_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [3:0]                  nbytes_s;
  logic [OFF_W+2:0]            shamt_s;
  logic [DATA_WIDTH-1:0]       keep_s;
  logic [DATA_WIDTH-1:0]       shifted_s;
  logic                        sign_s;

  // Build the access-width mask, then shift it into place for stores and
  // shift the word down for loads; the mask's top bit selects the sign bit.
  always_comb begin
    nbytes_s = size_bytes(size_i);
    shamt_s  = {offset_i, 3'b000};
    keep_s   = '0;
    for (int b = 0; b < NB; b++) begin
      if (4'(b) < nbytes_s) begin
        keep_s[8*b +: 8] = 8'hFF;
      end else begin
        keep_s[8*b +: 8] = 8'h00;
      end
    end
    wmask_o   = keep_s << shamt_s;
    wdata_o   = (wdata_i & keep_s) << shamt_s;
    shifted_s = rword_i >> shamt_s;
    sign_s    = |(shifted_s & keep_s & ~(keep_s >> 1));
    if (unsigned_i || !sign_s) begin
      rdata_o = shifted_s & keep_s;
    end else begin
      rdata_o = shifted_s | ~keep_s;
    end
  end

endmodule

// File: rtl/dmem_subword.sv
// Single-port data memory with byte/half/word/dword access, error checking,
// a one-cycle registered response and a word-per-cycle zeroing walk.
module dmem_subword
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err
);

  localparam int   NB        = DATA_WIDTH / 8;
  localparam int   OFF_W     = $clog2(NB);
  localparam int   IDX_W     = $clog2(DEPTH);
  localparam logic HAS_DWORD = (DATA_WIDTH == 64);

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]            resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [OFF_W-1:0]      offset_s;
  logic [OFF_W-1:0]      align_mask_s;
  logic [ADDR_WIDTH-1:0] word_s;
  logic [IDX_W-1:0]      idx_s;
  logic [1:0]            err_s;
  logic                  accept_s;
  logic                  store_ok_s;
  logic [DATA_WIDTH-1:0] rword_s;
  logic [DATA_WIDTH-1:0] wmask_s;
  logic [DATA_WIDTH-1:0] wdata_al_s;
  logic [DATA_WIDTH-1:0] rdata_ext_s;

  assign req_ready  = (state_q == ST_READY);
  assign accept_s   = req_valid && req_ready;
  assign offset_s   = req_addr[OFF_W-1:0];
  assign word_s     = req_addr >> OFF_W;
  assign idx_s      = word_s[IDX_W-1:0];
  assign rword_s    = mem_q[idx_s];
  assign store_ok_s = accept_s && req_we && (err_s == ERR_OK);

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  dmem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .size_i    (req_size),
    .unsigned_i(req_unsigned),
    .offset_i  (offset_s),
    .wdata_i   (req_wdata),
    .rword_i   (rword_s),
    .wmask_o   (wmask_s),
    .wdata_o   (wdata_al_s),
    .rdata_o   (rdata_ext_s)
  );

  // Error classification, highest priority first.
  always_comb begin
    align_mask_s = OFF_W'(size_bytes(req_size) - 4'd1);
    if ((req_size == SIZE_DWORD) && !HAS_DWORD) begin
      err_s = ERR_SIZE;
    end else if (|(offset_s & align_mask_s)) begin
      err_s = ERR_MISALIGN;
    end else if (word_s >= ADDR_WIDTH'(DEPTH)) begin
      err_s = ERR_RANGE;
    end else begin
      err_s = ERR_OK;
    end
  end

  // Controller next state and the registered response contents.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase

    resp_valid_d = accept_s;
    if (accept_s) begin
      resp_err_d = err_s;
    end else begin
      resp_err_d = ERR_OK;
    end
    if (accept_s && !req_we && (err_s == ERR_OK)) begin
      resp_rdata_d = rdata_ext_s;
    end else begin
      resp_rdata_d = '0;
    end
  end

  // Controller and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is deliberately not reset; the clear walk zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (store_ok_s) begin
      mem_q[idx_s] <= (rword_s & ~wmask_s) | (wdata_al_s & wmask_s);
    end
  end

endmodule

// File: tb/tb_dmem_subword.sv
// Scoreboard bench for dmem_subword: stimulus pushes expected responses, a
// negedge monitor pops and compares whenever resp_valid is seen.
module tb_dmem_subword;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  dmem_subword #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_req   (clear_req),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got rdata 0x%0h err %0b with nothing expected",
                 resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
        check({e.name, "_err"}, 64'(resp_err), 64'(e.err));
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                       input logic push = 1'b1, input logic clr = 1'b0);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: got req_ready 0 required 1", name);
    end else begin
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      clear_req    = clr;
      if (push) sb_q.push_back('{name, exp_rdata, exp_err});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      clear_req = 1'b0;
    end
  endtask

  // Caller must be positioned at a negedge; counts negedges with ready low.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", 64'(resp_rdata), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    rst_n = 1'b1;
    wait_ready("ready_after_reset", 64);

    issue("load0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 2'b00);

    issue("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 2'b00);
    issue("sb_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 32'h0, 2'b00);
    issue("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11AA_3344, 2'b00);

    issue("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_F080, 32'h0, 2'b00);
    issue("lb_20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFF_FF80, 2'b00);
    issue("lhu_20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_F080, 2'b00);
    issue("lh_20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'hFFFF_F080, 2'b00);
    issue("lbu_21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_00F0, 2'b00);

    issue("sh_21_mis", 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_1234, 32'h0, 2'b01);
    issue("lw_20_keep", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0000_F080, 2'b00);
    issue("lw_100_oor", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 2'b10);
    issue("sw_100_oor", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 2'b10);
    issue("size11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 2'b11);
    issue("size11_prio", 1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 32'h0, 2'b11);
    issue("mis_prio", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 2'b01);
    issue("lw_10_after", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11AA_3344, 2'b00);

    issue("clr_sw_4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h0000_0005, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    wait_ready("ready_after_clear", 64);
    issue("lw_4_cleared", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 2'b00);
    issue("lw_10_cleared", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 2'b00);

    issue("sw_8", 1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFE_0001, 32'h0, 2'b00);
    issue("lw_8_dropped", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 2'b00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_drop_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_drop_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midclear_rst_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    wait_ready("ready_after_midclear_rst", 64);
    issue("lw_8_after_rst", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 2'b00);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
